// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide arbiter between the IF and MEM request ports and the
// single external RAM/IO port. MEM has strict priority and preempts IF.
// The RAM returns read data one cycle after the address. A registered tag
// steers that byte back to the port that issued the read.
// Optional feature macro: MEMCTRL_IO_STALL_EN. When it is defined, a MEM
// write to IO space is held back while the IO output buffer is full.
module mem_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [7:0]        if_data_o,
    output logic              if_valid_o,
    output logic              if_abort_o,
    output logic              stall_if_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [7:0]        mem_wdata_i,
    output logic [7:0]        mem_rdata_o,
    output logic              mem_valid_o,
    output logic              mem_gnt_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_OWN,
        ST_MEM_OWN
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IF,
        TAG_MEM
    } tag_e;

    state_e     state_q, state_d;
    state_e     owner;
    tag_e       rd_tag_q, rd_tag_d;
    logic [7:0] if_hold_q, if_hold_d;
    logic [7:0] mem_hold_q, mem_hold_d;
    logic       io_hold;

`ifdef MEMCTRL_IO_STALL_EN
    // A MEM write to IO space is held while the IO buffer is full. IO reads are never held.
    assign io_hold = mem_req_i & mem_we_i & (mem_addr_i[17:16] == IO_BASE_HI) & io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign io_hold               = 1'b0;
`endif

    // State, read tag and data hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_tag_q   <= TAG_NONE;
            if_hold_q  <= '0;
            mem_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_tag_q   <= rd_tag_d;
            if_hold_q  <= if_hold_d;
            mem_hold_q <= mem_hold_d;
        end
    end

    // Next state: this cycle's port owner. A held IO write keeps IF off the port.
    always_comb begin
        owner = ST_IDLE;
        if (rst) begin
            owner = ST_IDLE;
        end else if (io_hold) begin
            owner = ST_IDLE;
        end else if (mem_req_i) begin
            owner = ST_MEM_OWN;
        end else if (if_req_i) begin
            owner = ST_IF_OWN;
        end
        state_d = owner;

        rd_tag_d = TAG_NONE;
        case (owner)
            ST_IF_OWN:  rd_tag_d = TAG_IF;
            ST_MEM_OWN: rd_tag_d = mem_we_i ? TAG_NONE : TAG_MEM;
            default:    rd_tag_d = TAG_NONE;
        endcase
    end

    // Outputs: RAM drive from the owner, read return steering, abort and stall
    always_comb begin
        mem_a       = '0;
        mem_wr      = 1'b0;
        mem_dout    = '0;
        mem_gnt_o   = 1'b0;
        case (owner)
            ST_MEM_OWN: begin
                mem_a     = mem_addr_i;
                mem_wr    = mem_we_i;
                mem_dout  = mem_wdata_i;
                mem_gnt_o = 1'b1;
            end
            ST_IF_OWN: begin
                mem_a = if_addr_i;
            end
            default: begin
                mem_a = '0;
            end
        endcase

        stall_if_o  = !rst && mem_req_i;
        if_abort_o  = !rst && (state_q == ST_IF_OWN) && if_req_i && mem_req_i;

        // The IF byte returning in an abort cycle belongs to the fetch being restarted: drop it.
        if_valid_o  = !rst && (rd_tag_q == TAG_IF) && !if_abort_o;
        mem_valid_o = !rst && (rd_tag_q == TAG_MEM);

        if_hold_d   = if_valid_o ? mem_din : if_hold_q;
        mem_hold_d  = mem_valid_o ? mem_din : mem_hold_q;

        if_data_o   = rst ? '0 : if_hold_d;
        mem_rdata_o = rst ? '0 : mem_hold_d;
    end

endmodule
